bg_scroll_renderer: RTL and testbench
=====================================

Name: bg_scroll_renderer

Overview:
Parametrised full-screen background renderer that maps the VGA raster (DrawX/DrawY) onto a palette-indexed source image. The mapping uses a power-of-two upscale and per-frame X/Y scroll offsets, with either wrap-around or border-clamp at the image edges. It drives an external synchronous background ROM and an external combinational palette. It registers 12-bit RGB into the VGA output path and sits between the VGA controller and the sprite/overlay mixer.

Parameters:
SRC_W, 320, source image width in pixels
SRC_H, 240, source image height in pixels
SCALE_SHIFT, 1, upscale factor = 2**SCALE_SHIFT in both axes; constraint 640>>SCALE_SHIFT <= SRC_W and 480>>SCALE_SHIFT <= SRC_H
ADDR_W, 17, ROM address width; constraint 2**ADDR_W >= SRC_W*SRC_H
IDX_W, 4, palette index width
BORDER_IDX, 0, palette index emitted for out-of-image pixels in clamp mode

Ports:
vga_clk  in  1  pixel clock; all state on rising edge
reset_n  in  1  asynchronous, active-low reset
DrawX  in  10  current raster X (0..799)
DrawY  in  10  current raster Y (0..524)
blank  in  1  1 = active video, 0 = blanking
scroll_x_in  in  10  new X scroll value
scroll_y_in  in  10  new Y scroll value
scroll_we  in  1  write scroll_x_in/scroll_y_in to shadow registers
wrap_mode  in  1  1 = wrap-around, 0 = clamp to BORDER_IDX; sampled per pixel
rom_addr  out  ADDR_W  registered address to synchronous ROM (1-cycle read latency)
rom_q  in  IDX_W  ROM data
pal_index  out  IDX_W  combinational index to palette
palette_red/green/blue  in  4 each  palette colour for pal_index
red/green/blue  out  4 each  registered pixel colour
scroll_err  out  1  sticky: an out-of-range scroll write was rejected

Behaviour:
- Reset (async assert, sync release): rom_addr=0, red/green/blue=0, scroll_err=0, shadow and active scroll registers=0, all pipeline valid/blank/border flags=0.
- Scroll write: if scroll_we=1 and scroll_x_in<SRC_W and scroll_y_in<SRC_H, both shadow registers load on that edge. Otherwise both shadow registers hold and scroll_err sets. Never a partial write.
- Frame latch: the active scroll registers load from the shadow registers on the edge where DrawX==0 and DrawY==480 (first vertical-blank line). If a valid scroll_we occurs on that same edge, the incoming values go directly into the active registers (bypass).
- Mid-frame writes never affect the frame in progress.
- Stage 0, edge k:
  - ux = DrawX>>SCALE_SHIFT, uy = DrawY>>SCALE_SHIFT.
  - sx = ux + scroll_x; sy = uy + scroll_y; both 11 bits.
  - Wrap mode: if sx>=SRC_W then sx-=SRC_W; likewise sy with SRC_H. A single conditional subtract is sufficient under the parameter constraints.
  - Clamp mode: if sx>=SRC_W or sy>=SRC_H, set border flag b1=1 and force rom_addr to 0.
  - rom_addr <= sy*SRC_W + sx (constant multiply, ADDR_W result).
  - blank_d1 <= blank; b1 as above.
- Stage 1, edge k+1: ROM presents rom_q. blank_d2 <= blank_d1; b2 <= b1.
- pal_index = b2 ? BORDER_IDX : rom_q (combinational).
- Stage 2, edge k+2: red/green/blue <= blank_d2 ? palette_* : 0.
- Latency: raster coordinates sampled at edge k produce RGB valid after edge k+2. The VGA controller delays hs/vs by 2 cycles to match.
- Pipeline is free-running; no stall. Raster coordinates outside the visible area are processed normally and masked by blank.
- Reset mid-frame: outputs go to 0 immediately. Scroll returns to 0,0 and takes effect on the first pixel after release.

Test Plan:
1. Reset; scroll 0,0, SCALE_SHIFT=1, wrap_mode=1, blank=1, DrawX=5, DrawY=3 at edge k -> rom_addr=322 after edge k; with ROM returning 7 and palette(7)=A/B/C, RGB=A/B/C after edge k+2.
2. Same as scenario 1 with blank=0 at edge k only -> RGB=0 after edge k+2; following pixel with blank=1 shows palette colour.
3. Scroll to 300,0, latched at DrawY=480; next frame DrawX=100, DrawY=0, wrap_mode=1 -> sx=350-320=30, rom_addr=30.
4. Same setup as scenario 3 with wrap_mode=0 -> pal_index=BORDER_IDX during stage 2, RGB=palette(BORDER_IDX).
5. scroll_we at DrawY=100 with (10,20) -> rom_addr unchanged for the rest of the frame; after the DrawX=0, DrawY=480 edge, pixel (0,0) gives rom_addr=20*320+10=6410. Also test a write on exactly that edge to confirm bypass.
6. scroll_we with scroll_y_in=240 -> shadow registers unchanged, scroll_err=1 and stays 1; assert reset_n=0 mid-line -> scroll_err=0 and RGB=0 without a clock edge.

Source files
------------

// File: rtl/bg_scroll_renderer.sv
// bg_scroll_renderer: full-screen scrolled/upscaled background renderer.
// Maps the raster (DrawX/DrawY) onto a palette-indexed source image through a
// power-of-two upscale and per-frame X/Y scroll, wrapping or clamping at the
// image edges. Three-stage free-running pipeline: address -> ROM -> RGB.
// Ports:
//   vga_clk, reset_n                 pixel clock, async active-low reset
//   DrawX, DrawY, blank              raster position and active-video flag
//   scroll_x_in/_y_in, scroll_we     scroll write into shadow registers
//   wrap_mode                        1 = wrap-around, 0 = clamp to BORDER_IDX
//   rom_addr / rom_q                 synchronous background ROM (1-cycle read)
//   pal_index / palette_*            combinational palette lookup
//   red, green, blue                 registered pixel colour
//   scroll_err                       sticky flag: out-of-range scroll write rejected
module bg_scroll_renderer #(
  parameter int unsigned SRC_W       = 320,
  parameter int unsigned SRC_H       = 240,
  parameter int unsigned SCALE_SHIFT = 1,
  parameter int unsigned ADDR_W      = 17,
  parameter int unsigned IDX_W       = 4,
  parameter int unsigned BORDER_IDX  = 0
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic [9:0]        scroll_x_in,
  input  logic [9:0]        scroll_y_in,
  input  logic              scroll_we,
  input  logic              wrap_mode,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [IDX_W-1:0]  rom_q,
  output logic [IDX_W-1:0]  pal_index,
  input  logic [3:0]        palette_red,
  input  logic [3:0]        palette_green,
  input  logic [3:0]        palette_blue,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              scroll_err
);

  localparam int unsigned CW = 11;
  localparam logic [CW-1:0]     SRC_W_C  = CW'(SRC_W);
  localparam logic [CW-1:0]     SRC_H_C  = CW'(SRC_H);
  localparam logic [ADDR_W-1:0] SRC_W_A  = ADDR_W'(SRC_W);
  localparam logic [IDX_W-1:0]  BORDER_C = IDX_W'(BORDER_IDX);

  logic [9:0]        shadow_x_q, shadow_x_d, shadow_y_q, shadow_y_d;
  logic [9:0]        act_x_q, act_x_d, act_y_q, act_y_d;
  logic              scroll_err_q, scroll_err_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              blank_d1_q, blank_d1_d, b1_q, b1_d;
  logic              blank_d2_q, blank_d2_d, b2_q, b2_d;
  logic [3:0]        red_q, red_d, green_q, green_d, blue_q, blue_d;

  logic              wr_ok, frame_start;
  logic [CW-1:0]     ux, uy, sx_raw, sy_raw, sx, sy;

  // Scroll write qualification and first-vblank-line detection
  always_comb begin
    wr_ok       = scroll_we && (CW'(scroll_x_in) < SRC_W_C) && (CW'(scroll_y_in) < SRC_H_C);
    frame_start = (DrawX == 10'd0) && (DrawY == 10'd480);
  end

  // Scroll registers: shadow takes valid writes, active updates only at frame start
  always_comb begin
    shadow_x_d   = shadow_x_q;
    shadow_y_d   = shadow_y_q;
    act_x_d      = act_x_q;
    act_y_d      = act_y_q;
    scroll_err_d = scroll_err_q;
    if (wr_ok) begin
      shadow_x_d = scroll_x_in;
      shadow_y_d = scroll_y_in;
    end else if (scroll_we) begin
      scroll_err_d = 1'b1;
    end
    if (frame_start) begin
      // A valid write on the latch edge bypasses the shadow
      act_x_d = wr_ok ? scroll_x_in : shadow_x_q;
      act_y_d = wr_ok ? scroll_y_in : shadow_y_q;
    end
  end

  // Stage 0: raster -> image coordinate -> ROM address
  always_comb begin
    ux     = CW'(DrawX >> SCALE_SHIFT);
    uy     = CW'(DrawY >> SCALE_SHIFT);
    sx_raw = ux + CW'(act_x_q);
    sy_raw = uy + CW'(act_y_q);
    sx     = sx_raw;
    sy     = sy_raw;
    b1_d   = 1'b0;
    if (wrap_mode) begin
      if (sx_raw >= SRC_W_C) sx = sx_raw - SRC_W_C;
      if (sy_raw >= SRC_H_C) sy = sy_raw - SRC_H_C;
    end else begin
      b1_d = (sx_raw >= SRC_W_C) || (sy_raw >= SRC_H_C);
    end
    rom_addr_d = b1_d ? '0 : (ADDR_W'(sy) * SRC_W_A + ADDR_W'(sx));
    blank_d1_d = blank;
  end

  // Stages 1 and 2: flag alignment with ROM data, then colour register
  always_comb begin
    blank_d2_d = blank_d1_q;
    b2_d       = b1_q;
    red_d      = blank_d2_q ? palette_red   : 4'd0;
    green_d    = blank_d2_q ? palette_green : 4'd0;
    blue_d     = blank_d2_q ? palette_blue  : 4'd0;
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_x_q   <= '0;
      shadow_y_q   <= '0;
      act_x_q      <= '0;
      act_y_q      <= '0;
      scroll_err_q <= 1'b0;
      rom_addr_q   <= '0;
      blank_d1_q   <= 1'b0;
      b1_q         <= 1'b0;
      blank_d2_q   <= 1'b0;
      b2_q         <= 1'b0;
      red_q        <= '0;
      green_q      <= '0;
      blue_q       <= '0;
    end else begin
      shadow_x_q   <= shadow_x_d;
      shadow_y_q   <= shadow_y_d;
      act_x_q      <= act_x_d;
      act_y_q      <= act_y_d;
      scroll_err_q <= scroll_err_d;
      rom_addr_q   <= rom_addr_d;
      blank_d1_q   <= blank_d1_d;
      b1_q         <= b1_d;
      blank_d2_q   <= blank_d2_d;
      b2_q         <= b2_d;
      red_q        <= red_d;
      green_q      <= green_d;
      blue_q       <= blue_d;
    end
  end

  assign pal_index  = b2_q ? BORDER_C : rom_q;
  assign rom_addr   = rom_addr_q;
  assign red        = red_q;
  assign green      = green_q;
  assign blue       = blue_q;
  assign scroll_err = scroll_err_q;

endmodule

// File: tb/tb_bg_scroll_renderer.sv
// Bench for bg_scroll_renderer: models ROM and palette, predicts outputs from
// image-space arithmetic, and compares every cycle plus directed literal checks.
module tb_bg_scroll_renderer;

  localparam int unsigned AW = 17;
  localparam int unsigned IW = 4;

  logic          vga_clk = 1'b0;
  logic          reset_n = 1'b1;
  logic [9:0]    DrawX = '0, DrawY = '0;
  logic          blank = 1'b0;
  logic [9:0]    scroll_x_in = '0, scroll_y_in = '0;
  logic          scroll_we = 1'b0;
  logic          wrap_mode = 1'b1;
  logic [AW-1:0] rom_addr;
  logic [IW-1:0] rom_q = '0;
  logic [IW-1:0] pal_index;
  logic [3:0]    palette_red, palette_green, palette_blue;
  logic [3:0]    red, green, blue;
  logic          scroll_err;

  int total = 0;
  int bad   = 0;

  bg_scroll_renderer dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY),
    .blank(blank), .scroll_x_in(scroll_x_in), .scroll_y_in(scroll_y_in),
    .scroll_we(scroll_we), .wrap_mode(wrap_mode), .rom_addr(rom_addr),
    .rom_q(rom_q), .pal_index(pal_index), .palette_red(palette_red),
    .palette_green(palette_green), .palette_blue(palette_blue),
    .red(red), .green(green), .blue(blue), .scroll_err(scroll_err)
  );

  always #5 vga_clk = ~vga_clk;

  // Image content: address 322 holds 7, otherwise a nibble mix of the address
  function automatic logic [3:0] rom_fn(input logic [AW-1:0] a);
    return (a == 17'd322) ? 4'd7 : (a[3:0] ^ a[7:4]);
  endfunction

  // External synchronous ROM and combinational palette (index 7 -> A/B/C)
  always @(posedge vga_clk) rom_q <= rom_fn(rom_addr);
  assign palette_red   = pal_index + 4'd3;
  assign palette_green = pal_index + 4'd4;
  assign palette_blue  = pal_index + 4'd5;

  // Model state: scroll as seen by the frame, and expected outputs in flight
  int            m_sh_x, m_sh_y, m_act_x, m_act_y, since_rst;
  logic          m_err;
  logic [AW-1:0] e_addr;
  logic [11:0]   e_rgb, p0, p1;
  logic [3:0]    e_pal, i0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sh_x = 0; m_sh_y = 0; m_act_x = 0; m_act_y = 0;
    m_err = 1'b0; since_rst = 0;
    e_addr = '0; e_rgb = '0; p0 = '0; p1 = '0; e_pal = '0; i0 = '0;
  endtask

  // One clock edge of the model, using the inputs that were presented to it
  task automatic model_edge();
    int sx, sy, addr;
    bit brd, ok;
    logic [3:0]  idx;
    logic [11:0] col;
    sx = int'(DrawX) / 2 + m_act_x;
    sy = int'(DrawY) / 2 + m_act_y;
    brd = 1'b0;
    if (wrap_mode) begin
      if (sx >= 320) sx = sx - 320;
      if (sy >= 240) sy = sy - 240;
    end else begin
      brd = (sx >= 320) || (sy >= 240);
    end
    addr = brd ? 0 : (sy * 320 + sx) % 131072;
    idx  = brd ? 4'd0 : rom_fn(AW'(addr));
    col  = blank ? {4'(idx + 4'd3), 4'(idx + 4'd4), 4'(idx + 4'd5)} : 12'h000;
    e_rgb = p1; p1 = p0; p0 = col;
    e_pal = i0; i0 = idx;
    e_addr = AW'(addr);
    ok = scroll_we && (scroll_x_in < 10'd320) && (scroll_y_in < 10'd240);
    if (DrawX == 10'd0 && DrawY == 10'd480) begin
      m_act_x = ok ? int'(scroll_x_in) : m_sh_x;
      m_act_y = ok ? int'(scroll_y_in) : m_sh_y;
    end
    if (ok) begin
      m_sh_x = int'(scroll_x_in);
      m_sh_y = int'(scroll_y_in);
    end else if (scroll_we) begin
      m_err = 1'b1;
    end
    since_rst++;
  endtask

  task automatic step(input int x, input int y, input bit bl, input bit wr,
                      input bit we = 1'b0, input int sxi = 0, input int syi = 0);
    DrawX = 10'(x); DrawY = 10'(y); blank = bl; wrap_mode = wr;
    scroll_we = we; scroll_x_in = 10'(sxi); scroll_y_in = 10'(syi);
    @(posedge vga_clk);
    model_edge();
    #1;
    scroll_we = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_rgb", 32'({red, green, blue}), 32'd0);
    chk("rst_scroll_err", 32'(scroll_err), 32'd0);
    @(posedge vga_clk);
    #2;
    reset_n = 1'b1;
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge vga_clk) begin
    if (reset_n) begin
      chk("cyc_rom_addr", 32'(rom_addr), 32'(e_addr));
      chk("cyc_rgb", 32'({red, green, blue}), 32'(e_rgb));
      chk("cyc_scroll_err", 32'(scroll_err), 32'(m_err));
      if (since_rst >= 2) chk("cyc_pal_index", 32'(pal_index), 32'(e_pal));
    end
  end

  initial begin
    #1;
    do_reset();

    // Unscrolled pixel (5,3) -> image (2,1) -> address 322, ROM 7 -> A/B/C
    step(5, 3, 1, 1);
    chk("t1_addr", 32'(rom_addr), 32'd322);
    step(6, 3, 1, 1);
    step(7, 3, 1, 1);
    chk("t1_rgb", 32'({red, green, blue}), 32'hABC);

    // Blanked pixel is black; following active pixel (6,3)->addr 323->idx 7
    step(5, 3, 0, 1);
    step(6, 3, 1, 1);
    step(7, 3, 1, 1);
    chk("t2_rgb_blank", 32'({red, green, blue}), 32'h000);
    step(8, 3, 1, 1);
    chk("t2_rgb_next", 32'({red, green, blue}), 32'hABC);

    // Scroll 300,0 latched at first vblank line; wrap: 50+300-320 = 30
    step(10, 10, 1, 1, 1, 300, 0);
    step(0, 480, 1, 1);
    step(100, 0, 1, 1);
    chk("t3_addr_wrap", 32'(rom_addr), 32'd30);

    // Clamp mode: out-of-image -> border index 0 -> palette 3/4/5
    step(100, 0, 1, 0);
    chk("t4_addr_clamp", 32'(rom_addr), 32'd0);
    step(101, 0, 1, 0);
    chk("t4_pal_border", 32'(pal_index), 32'd0);
    step(102, 0, 1, 0);
    chk("t4_rgb_border", 32'({red, green, blue}), 32'h345);

    // Mid-frame write does not affect current frame: (2,100) -> 50*320+301
    step(0, 100, 1, 1, 1, 10, 20);
    step(2, 100, 1, 1);
    chk("t5_addr_midframe", 32'(rom_addr), 32'd16301);
    step(0, 480, 1, 1);
    step(0, 0, 1, 1);
    chk("t5_addr_latched", 32'(rom_addr), 32'd6410);

    // Write on the latch edge bypasses the shadow: 9*320+7
    step(4, 50, 1, 1, 1, 5, 5);
    step(0, 480, 1, 1, 1, 7, 9);
    step(0, 0, 1, 1);
    chk("t5_addr_bypass", 32'(rom_addr), 32'd2887);

    // Rejected writes: sticky error, no partial update of either axis
    step(0, 10, 1, 1, 1, 3, 240);
    chk("t6_err_set", 32'(scroll_err), 32'd1);
    step(0, 11, 1, 1, 1, 320, 5);
    step(0, 480, 1, 1);
    step(0, 0, 1, 1);
    chk("t6_addr_unchanged", 32'(rom_addr), 32'd2887);
    chk("t6_err_sticky", 32'(scroll_err), 32'd1);

    // Mid-line reset clears outputs and scroll without a clock edge
    step(40, 0, 1, 1);
    step(41, 0, 1, 1);
    step(42, 0, 1, 1);
    chk("t6_rgb_pre_reset", 32'({red, green, blue}), 32'h123);
    #2;
    do_reset();
    step(5, 3, 1, 1);
    chk("t6_addr_post_reset", 32'(rom_addr), 32'd322);

    // Mixed directed sweep with periodic frame latches and scroll writes
    for (int i = 0; i < 60; i++) begin
      if (i % 12 == 0) step(0, 480, 1, i % 24 == 0);
      else step(int'($urandom_range(0, 799)), int'($urandom_range(0, 524)),
                bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                (i % 5 == 0), int'($urandom_range(0, 340)), int'($urandom_range(0, 260)));
    end
    step(0, 0, 1, 1);
    step(0, 0, 1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
